// File: rtl/home_event_arbiter.sv
// home_event_arbiter: hold-time arbiter over sensor, heater and cooler request channels
module home_event_arbiter #(
  parameter int NUM_SENSORS = 5,
  parameter int TEMP_W      = 6,
  parameter int HEAT_TH     = 15,
  parameter int COOL_TH     = 30,
  parameter int MIN_HOLD    = 4,
  parameter int ROT_PERIOD  = 8,
  localparam int M          = NUM_SENSORS + 2,
  localparam int IDX_W      = $clog2(M),
  localparam int HW         = $clog2(MIN_HOLD + 1),
  localparam int RW         = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] sensor_req,
  input  logic                   temp_valid,
  input  logic [TEMP_W-1:0]      temperature,
  input  logic [1:0]             arb_mode,
  output logic [M-1:0]           grant,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t           r_state, w_state_nx;
  logic [M-1:0]     r_grant, w_req;
  logic             r_valid, r_dir, w_any, w_arb;
  logic [IDX_W-1:0] r_idx, r_rr_ptr, w_lo, w_hi, w_rr, w_j, w_win;
  logic [HW-1:0]    r_hold;
  logic [RW-1:0]    r_rot;
  // request vector: sensors, then heater, then cooler (thermal requests gated by temp_valid)
  always_comb begin
    w_req = {temp_valid && (int'(temperature) > COOL_TH),
             temp_valid && (int'(temperature) < HEAT_TH),
             sensor_req};
    w_any = |w_req;
  end
  // candidate winners for each policy; later loop iterations override earlier ones
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_rr = '0;
    w_j  = '0;
    for (int i = M - 1; i >= 0; i--) if (w_req[i]) w_lo = IDX_W'(i);
    for (int i = 0; i < M; i++) if (w_req[i]) w_hi = IDX_W'(i);
    for (int i = M; i >= 1; i--) begin
      w_j = IDX_W'((int'(r_rr_ptr) + i) % M);
      if (w_req[w_j]) w_rr = w_j;
    end
    w_win = (arb_mode == 2'b00) ? w_lo :
            (arb_mode == 2'b01) ? w_hi :
            (arb_mode == 2'b10) ? (r_dir ? w_hi : w_lo) : w_rr;
  end
  // next state: arbitrate when idle or when the hold has expired
  always_comb begin
    w_arb      = w_any && (r_state == IDLE || r_hold == '0);
    w_state_nx = (r_state == ACTIVE && r_hold != '0) ? ACTIVE : (w_any ? ACTIVE : IDLE);
  end
  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end
  // grant, hold counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_hold   <= '0;
      r_rr_ptr <= IDX_W'(M - 1);
    end else if (w_arb) begin
      r_grant  <= M'(1) << w_win;
      r_valid  <= 1'b1;
      r_idx    <= w_win;
      r_hold   <= HW'(MIN_HOLD - 1);
      r_rr_ptr <= w_win;
    end else if (r_state == ACTIVE && r_hold != '0) begin
      r_hold   <= r_hold - HW'(1);
    end else if (w_state_nx == IDLE) begin
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
    end
  end
  // direction rotation counts every cycle with any request, independent of mode
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rot <= '0;
      r_dir <= 1'b0;
    end else if (w_any) begin
      r_rot <= (r_rot == RW'(ROT_PERIOD - 1)) ? '0 : r_rot + RW'(1);
      r_dir <= (r_rot == RW'(ROT_PERIOD - 1)) ? ~r_dir : r_dir;
    end
  end
  // outputs come straight from registers
  always_comb begin
    grant       = r_grant;
    grant_valid = r_valid;
    grant_idx   = r_idx;
  end
endmodule

// File: tb/tb_home_event_arbiter.sv
// tb_home_event_arbiter: random and directed checks against a behavioural arbiter model
module tb_home_event_arbiter;
  localparam int NS = 5, M = 7, MH = 4, RP = 8;
  logic          clk = 0, reset = 0, temp_valid = 0;
  logic [NS-1:0] sensor_req = '0;
  logic [5:0]    temperature = '0;
  logic [1:0]    arb_mode = '0;
  logic [M-1:0]  grant;
  logic          grant_valid;
  logic [2:0]    grant_idx;
  int n_tests = 0, n_fail = 0;
  bit started = 0;
  int m_g = -1, m_age = 0, m_rot = 0, m_dir = 0, m_rr = M - 1;
  bit [M-1:0] m_req;

  home_event_arbiter dut (
    .clk(clk), .reset(reset), .sensor_req(sensor_req), .temp_valid(temp_valid),
    .temperature(temperature), .arb_mode(arb_mode), .grant(grant),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  function automatic int pick(bit [M-1:0] r, int mode, int dir, int rr);
    int lo = -1, hi = -1, w = -1;
    for (int k = 0; k < M; k++) if (r[k]) begin
      if (lo < 0) lo = k;
      hi = k;
    end
    for (int k = 1; k <= M && w < 0; k++) if (r[(rr + k) % M]) w = (rr + k) % M;
    case (mode)
      0: return lo;
      1: return hi;
      2: return dir ? hi : lo;
      default: return w;
    endcase
  endfunction

  // model: grant shown for MH cycles, then re-pick or go idle
  always @(posedge clk) begin
    if (!reset) begin
      m_g = -1; m_age = 0; m_rot = 0; m_dir = 0; m_rr = M - 1;
    end else begin
      m_req = {temp_valid && temperature > 30, temp_valid && temperature < 15, sensor_req};
      if (m_g >= 0 && m_age < MH) m_age++;
      else if (m_req != 0) begin
        m_g = pick(m_req, int'(arb_mode), m_dir, m_rr);
        m_age = 1;
        m_rr = m_g;
      end else begin
        m_g = -1; m_age = 0;
      end
      if (m_req != 0) begin
        m_rot++;
        if (m_rot == RP) begin m_rot = 0; m_dir ^= 1; end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("model_grant", int'(grant), m_g < 0 ? 0 : (1 << m_g));
    chk("model_valid", int'(grant_valid), m_g >= 0 ? 1 : 0);
    chk("model_idx", int'(grant_idx), m_g < 0 ? 0 : m_g);
  end

  task automatic lit(string name, int idx, int v);
    chk({name, "_idx"}, int'(grant_idx), idx);
    chk({name, "_valid"}, int'(grant_valid), v);
    chk({name, "_grant"}, int'(grant), v ? (1 << idx) : 0);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0; sensor_req = '0; temp_valid = 0; temperature = '0; arb_mode = '0;
    step(1);
    reset = 1;
  endtask

  initial begin
    step(2);
    started = 1;
    step(1);
    lit("reset_state", 0, 0);
    do_reset();
    arb_mode = 2'b00; sensor_req = 5'b10100;
    step(1); lit("fixed_c1", 2, 1);
    step(3); lit("fixed_c4", 2, 1);
    step(1); lit("fixed_rearb_c5", 2, 1);
    sensor_req = '0;
    step(5); lit("fixed_idle", 0, 0);
    do_reset();
    arb_mode = 2'b01; temp_valid = 1; temperature = 6'd40; sensor_req = 5'b00001;
    step(1); lit("rev_cooler", 6, 1);
    temperature = 6'd20;
    step(4); lit("rev_sensor0", 0, 1);
    temperature = 6'd10;
    step(4); lit("rev_heater", 5, 1);
    do_reset();
    arb_mode = 2'b11; sensor_req = 5'b11111;
    step(1); lit("rr_0", 0, 1);
    for (int k = 1; k <= 5; k++) begin
      step(4);
      lit("rr_seq", k % 5, 1);
    end
    do_reset();
    arb_mode = 2'b10; sensor_req = 5'b10001;
    step(1); lit("alt_c1", 0, 1);
    step(7); lit("alt_c8", 0, 1);
    step(1); lit("alt_c9", 4, 1);
    do_reset();
    arb_mode = 2'b00; sensor_req = 5'b01000;
    step(2);
    sensor_req = 5'b01001;
    step(1); lit("hold_c3", 3, 1);
    step(1); lit("hold_c4", 3, 1);
    sensor_req = '0;
    step(1); lit("hold_idle", 0, 0);
    do_reset();
    arb_mode = 2'b01; sensor_req = 5'b10000;
    step(1); lit("rst_mid_pre", 4, 1);
    reset = 0;
    step(1); lit("rst_mid", 0, 0);
    reset = 1; arb_mode = 2'b10; sensor_req = 5'b10001;
    step(1); lit("rst_release", 0, 1);
    for (int c = 0; c < 3000; c++) begin
      sensor_req  = ($urandom_range(0, 3) == 0) ? '0 : NS'($urandom);
      temp_valid  = 1'($urandom);
      temperature = 6'($urandom);
      if ($urandom_range(0, 9) == 0) arb_mode = 2'($urandom);
      reset = ($urandom_range(0, 149) != 0);
      step(1);
    end
    reset = 1;
    step(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
